// File: rtl/timer.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload, maskable IRQ.
// Optional clock prescaler on CTRL[6:4] enabled by defining TIMER_PRESCALE_EN.
module timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        en_r, en_s;
  logic [1:0]  mode_r, mode_s;
  logic        im_r, im_s;
  logic [31:0] preset_r, preset_s;
  logic [31:0] count_r, count_s;
  logic        irq_flag_r, irq_flag_s;
  logic        irq_r;
  logic [2:0]  p_s;
  logic        tick_s;
  logic        wr_cfg_s;
  logic        unused_s;

  assign wr_cfg_s = WE && ((Addr[3:2] == 2'd0) || (Addr[3:2] == 2'd1));

`ifdef TIMER_PRESCALE_EN
  logic [2:0] p_r, p_next_s;
  logic [7:0] pcnt_r, pcnt_s, pmask_s;

  assign p_s      = p_r;
  assign pmask_s  = (8'd1 << p_r) - 8'd1;
  assign tick_s   = ((pcnt_r & pmask_s) == pmask_s);
  assign unused_s = ^{Addr[31:4], Addr[1:0], Din[31:7]};
`else
  assign p_s      = 3'd0;
  assign tick_s   = 1'b1;
  assign unused_s = ^{Addr[31:4], Addr[1:0], Din[31:4]};
`endif

  // Next-state and register update logic; a config write overrides every state action.
  always_comb begin
    state_s    = state_r;
    en_s       = en_r;
    mode_s     = mode_r;
    im_s       = im_r;
    preset_s   = preset_r;
    count_s    = count_r;
    irq_flag_s = irq_flag_r;
`ifdef TIMER_PRESCALE_EN
    p_next_s   = p_r;
    pcnt_s     = pcnt_r + 8'd1;
`endif
    if (wr_cfg_s) begin
      state_s    = IDLE;
      irq_flag_s = 1'b0;
`ifdef TIMER_PRESCALE_EN
      pcnt_s     = 8'd0;
`endif
      if (Addr[3:2] == 2'd0) begin
        en_s   = Din[0];
        mode_s = Din[2:1];
        im_s   = Din[3];
`ifdef TIMER_PRESCALE_EN
        p_next_s = Din[6:4];
`endif
      end else begin
        preset_s = Din;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (en_r) begin
            state_s = LOAD;
          end else begin
            state_s = IDLE;
          end
        end
        LOAD: begin
          count_s    = preset_r;
          irq_flag_s = 1'b0;
          state_s    = CNT;
`ifdef TIMER_PRESCALE_EN
          pcnt_s     = 8'd0;
`endif
        end
        CNT: begin
          if (!en_r) begin
            state_s = IDLE;
          end else if (tick_s) begin
            if (count_r > 32'd1) begin
              count_s = count_r - 32'd1;
            end else begin
              count_s = 32'd0;
              state_s = INT;
            end
          end else begin
            state_s = CNT;
          end
        end
        INT: begin
          irq_flag_s = 1'b1;
          // Only MODE=01 reloads; 00 and the undefined 1x encodings behave as one-shot.
          if (mode_r == 2'b01) begin
            state_s = LOAD;
          end else begin
            en_s    = 1'b0;
            state_s = IDLE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and register file; IRQ is registered from the next flag/mask values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      en_r       <= 1'b0;
      mode_r     <= 2'b00;
      im_r       <= 1'b0;
      preset_r   <= 32'd0;
      count_r    <= 32'd0;
      irq_flag_r <= 1'b0;
      irq_r      <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      p_r        <= 3'd0;
      pcnt_r     <= 8'd0;
`endif
    end else begin
      state_r    <= state_s;
      en_r       <= en_s;
      mode_r     <= mode_s;
      im_r       <= im_s;
      preset_r   <= preset_s;
      count_r    <= count_s;
      irq_flag_r <= irq_flag_s;
      irq_r      <= irq_flag_s & im_s;
`ifdef TIMER_PRESCALE_EN
      p_r        <= p_next_s;
      pcnt_r     <= pcnt_s;
`endif
    end
  end

  // Zero-latency register readback.
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'd0:    Dout = {25'd0, p_s, im_r, mode_r, en_r};
      2'd1:    Dout = preset_r;
      2'd2:    Dout = count_r;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_r;

endmodule
